dvp_source: RTL

//  OV7670-style DVP transmitter: the sensor end of the camera capture interface (pclk/href/vsync/8-bit data).

---
 rtl/dvp_source.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dvp_source.sv
// dvp_source - OV7670-style DVP transmitter (camera sensor end).
// Serialises RGB565 pixels high byte first onto an 8-bit bus. The bus runs with
// pclk = clkMain/2 and has programmable line and frame blanking.
// Optional feature macro: DVP_PATTERN_EN. When it is defined and pat_sel=1, the
// pixels come from internal 8-bar colour bars instead of pix_data/pix_valid.
// Ports:
//   clkMain, rstMain      : clock (rising edge), async active-low reset
//   enable                : start frames / keep streaming back-to-back
//   pat_sel               : select colour bars (DVP_PATTERN_EN builds only)
//   pix_data/valid/ready  : pixel input handshake, accepted on valid && ready
//   ca_pclk/href/vsync    : DVP timing outputs
//   ca_data               : DVP byte bus
//   frame_start           : 1-clk pulse at vsync rise
//   busy                  : frame in progress (vsync rise to end of front porch)
//   underrun              : sticky, a pixel was due while pix_valid was low
// Every line/porch parameter must be >= 1.
module dvp_source #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clkMain,
  input  logic        rstMain,
  input  logic        enable,
  input  logic        pat_sel,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        ca_pclk,
  output logic        ca_href,
  output logic        ca_vsync,
  output logic [7:0]  ca_data,
  output logic        frame_start,
  output logic        busy,
  output logic        underrun
);

  localparam int unsigned LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
  localparam int unsigned ACT_BYTES  = 2 * H_ACTIVE;
  localparam int unsigned M1 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned M2 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_LINES = (M1 > M2) ? M1 : M2;
  localparam int unsigned BW = $clog2(LINE_BYTES);
  localparam int unsigned LW = $clog2(MAX_LINES + 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [LW-1:0]   line_q, line_d;
  logic [LW-1:0]   lim;
  logic            start_d;
  logic            ph_q;
  logic            href_q, vsync_q, fs_q, busy_q, ready_q, under_q;
  logic [7:0]      data_q, lo_q;
  logic            act_byte_d, hi_slot, use_pat, ready_d;
  logic [15:0]     pix_new;

`ifdef DVP_PATTERN_EN
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
`else
  logic unused_pat_sel;
  assign unused_pat_sel = pat_sel;
`endif

  // Position of the byte period that starts at the next byte edge. It is evaluated
  // on every clk, and the registers take it only when ph_q=1 (pclk falling).
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    start_d = 1'b0;
    case (state_q)
      S_VSYNC:  lim = LW'(VSYNC_LINES);
      S_VBACK:  lim = LW'(V_BACK);
      S_ACTIVE: lim = LW'(V_ACTIVE);
      S_VFRONT: lim = LW'(V_FRONT);
      default:  lim = '0;
    endcase
    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d = S_VSYNC;
        byte_d  = '0;
        line_d  = '0;
        start_d = 1'b1;
      end
    end else if (byte_q != BW'(LINE_BYTES - 1)) begin
      byte_d = byte_q + 1'b1;
    end else begin
      byte_d = '0;
      if (line_q == lim - 1'b1) begin
        line_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          S_VFRONT: begin
            if (enable) begin
              state_d = S_VSYNC;
              start_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
          default:  state_d = S_IDLE;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end

    act_byte_d = (state_d == S_ACTIVE) && (32'(byte_d) < ACT_BYTES);
    hi_slot    = act_byte_d && !byte_d[0];
`ifdef DVP_PATTERN_EN
    use_pat = pat_sel;
    pix_new = use_pat ? bar_colour(3'((32'(byte_d) >> 1) / (H_ACTIVE / 8)))
                      : (pix_valid ? pix_data : 16'h0000);
`else
    use_pat = 1'b0;
    pix_new = pix_valid ? pix_data : 16'h0000;
`endif
    ready_d = hi_slot && !use_pat;
  end

  always_ff @(posedge clkMain or negedge rstMain) begin
    if (!rstMain) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      ph_q    <= 1'b0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      under_q <= 1'b0;
      data_q  <= '0;
      lo_q    <= '0;
    end else begin
      ph_q <= ~ph_q;
      fs_q <= 1'b0;
      if (ph_q) begin
        // Byte edge: advance the position and present the byte for the new period.
        state_q <= state_d;
        byte_q  <= byte_d;
        line_q  <= line_d;
        fs_q    <= start_d;
        vsync_q <= (state_d == S_VSYNC);
        busy_q  <= (state_d != S_IDLE);
        href_q  <= act_byte_d;
        ready_q <= 1'b0;
        if (hi_slot) begin
          data_q <= pix_new[15:8];
          lo_q   <= pix_new[7:0];
          if (!use_pat && !pix_valid) under_q <= 1'b1;
        end else if (act_byte_d) begin
          data_q <= lo_q;
        end else begin
          data_q <= '0;
        end
      end else begin
        // ph=1 clk ahead of a high-byte edge: raise ready for exactly that clk.
        ready_q <= ready_d;
      end
    end
  end

  assign pix_ready   = ready_q;
  assign ca_pclk     = ph_q;
  assign ca_href     = href_q;
  assign ca_vsync    = vsync_q;
  assign ca_data     = data_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign underrun    = under_q;

endmodule
